// File: rtl/adler32_checker_if.sv
// Byte-stream and verdict signals between a frame source and the Adler-32 checker.
// The source drives the byte stream; the checker drives ready, the verdict and the running checksum.
interface adler32_checker_if;
  logic        data_valid;
  logic        last_data;
  logic [7:0]  data;
  logic        ready;
  logic        result_valid;
  logic        checksum_ok;
  logic [31:0] computed;

  modport master (
    output data_valid,
    output last_data,
    output data,
    input  ready,
    input  result_valid,
    input  checksum_ok,
    input  computed
  );

  modport slave (
    input  data_valid,
    input  last_data,
    input  data,
    output ready,
    output result_valid,
    output checksum_ok,
    output computed
  );
endinterface

// File: rtl/adler32_checker.sv
// Receive-side Adler-32 checker: recomputes the checksum over a framed payload, captures the
// trailing 4-byte checksum (MSB first) and reports the verdict with a one-cycle pulse.
module adler32_checker #(
  parameter int unsigned MODULUS = 65521
) (
  input logic              clock,
  input logic              rst_n,
  adler32_checker_if.slave bus
);

  localparam logic [16:0] ModW = 17'(MODULUS);

  typedef enum logic [1:0] {
    StPayload,
    StCksum,
    StReport
  } state_e;

  state_e      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [1:0]  cnt_q;
  logic [31:0] rcv_q;
  logic        ready_q;
  logic        result_valid_q;
  logic        checksum_ok_q;

  logic        accept;
  logic [15:0] a_next;
  logic [15:0] b_next;
  logic [31:0] rcv_next;

  // A and B are always below MODULUS, so one conditional subtract reduces the sum.
  function automatic logic [15:0] mod_add(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= ModW) begin
      s = s - ModW;
    end
    return s[15:0];
  endfunction

  always_comb begin
    accept   = bus.data_valid & ready_q;
    a_next   = mod_add(a_q, {8'd0, bus.data});
    b_next   = mod_add(b_q, a_next);
    rcv_next = {rcv_q[23:0], bus.data};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StPayload;
      a_q            <= 16'd1;
      b_q            <= 16'd0;
      cnt_q          <= 2'd0;
      rcv_q          <= 32'd0;
      ready_q        <= 1'b1;
      result_valid_q <= 1'b0;
      checksum_ok_q  <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      checksum_ok_q  <= 1'b0;
      unique case (state_q)
        StPayload: begin
          if (accept) begin
            a_q <= a_next;
            b_q <= b_next;
            if (bus.last_data) begin
              state_q <= StCksum;
              cnt_q   <= 2'd0;
            end
          end
        end
        StCksum: begin
          if (accept) begin
            rcv_q <= rcv_next;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              // Verdict is registered here so it appears exactly in the REPORT cycle.
              state_q        <= StReport;
              ready_q        <= 1'b0;
              result_valid_q <= 1'b1;
              checksum_ok_q  <= (rcv_next == {b_q, a_q});
            end
          end
        end
        StReport: begin
          state_q <= StPayload;
          ready_q <= 1'b1;
          a_q     <= 16'd1;
          b_q     <= 16'd0;
          cnt_q   <= 2'd0;
        end
        default: begin
          state_q <= StPayload;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready        = ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.checksum_ok  = checksum_ok_q;
  assign bus.computed     = {b_q, a_q};

endmodule

// File: tb/tb_adler32_checker.sv
// Directed self-checking bench for adler32_checker: known frames with hand-computed checksums,
// gaps, back-to-back frames and mid-frame reset.
module tb_adler32_checker;

  logic clock;
  logic rst_n;
  adler32_checker_if bus ();

  adler32_checker #(.MODULUS(65521)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int pulse_cnt = 0;
  int pass_cnt = 0;
  int ready_low_cnt = 0;
  int stray_ok_cnt = 0;
  logic [31:0] pulse_comp = 32'd0;

  always @(negedge clock) begin
    if (bus.result_valid) begin
      pulse_cnt++;
      if (bus.checksum_ok) pass_cnt++;
      pulse_comp = bus.computed;
    end else if (bus.checksum_ok) begin
      stray_ok_cnt++;
    end
    if (rst_n && !bus.ready) ready_low_cnt++;
  end

  // Presents one byte and holds it until accepted; returns the number of cycles ready was low.
  task automatic send(input logic [7:0] b, input logic last, output int waits);
    waits = 0;
    bus.data       = b;
    bus.data_valid = 1'b1;
    bus.last_data  = last;
    @(negedge clock);
    while (!bus.ready && waits < 20) begin
      @(negedge clock);
      waits++;
    end
    if (waits >= 20) begin
      errors++;
      $display("FAIL send_timeout: ready stayed low for %0d cycles, required at most 1", waits);
    end
    @(posedge clock);
    #1;
    bus.data_valid = 1'b0;
    bus.last_data  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input logic [31:0] ck);
    int w;
    for (int i = 0; i < pl.size(); i++) send(pl[i], (i == pl.size() - 1), w);
    for (int i = 3; i >= 0; i--) send(ck[8*i +: 8], 1'b0, w);
  endtask

  function automatic void wiki(output logic [7:0] q[$]);
    q = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
  endfunction

  task automatic test_reset;
    rst_n          = 1'b0;
    bus.data_valid = 1'b0;
    bus.last_data  = 1'b0;
    bus.data       = 8'h00;
    #12;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, want 1", bus.ready);
    end
    checks++;
    if (bus.result_valid !== 1'b0) begin
      errors++; $display("FAIL reset_result_valid: got %b, want 0", bus.result_valid);
    end
    checks++;
    if (bus.checksum_ok !== 1'b0) begin
      errors++; $display("FAIL reset_checksum_ok: got %b, want 0", bus.checksum_ok);
    end
    checks++;
    if (bus.computed !== 32'h0000_0001) begin
      errors++; $display("FAIL reset_computed: got %h, want 00000001", bus.computed);
    end
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_wikipedia;
    logic [7:0] q[$];
    int p0, ok0;
    p0 = pulse_cnt; ok0 = pass_cnt;
    wiki(q);
    send_frame(q, 32'h11E6_0398);
    @(posedge clock);
    #1;
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++; $display("FAIL wiki_pulses: got %0d, want 1", pulse_cnt - p0);
    end
    checks++;
    if (pass_cnt - ok0 !== 1) begin
      errors++; $display("FAIL wiki_ok: got %0d passing pulses, want 1", pass_cnt - ok0);
    end
    checks++;
    if (pulse_comp !== 32'h11E6_0398) begin
      errors++; $display("FAIL wiki_computed: got %h, want 11e60398", pulse_comp);
    end
    checks++;
    if (bus.computed !== 32'h0000_0001) begin
      errors++; $display("FAIL wiki_restart: got %h, want 00000001", bus.computed);
    end
  endtask

  task automatic test_single_byte;
    logic [7:0] q[$];
    int p0, ok0;
    q = '{8'h61};
    p0 = pulse_cnt; ok0 = pass_cnt;
    send_frame(q, 32'h0062_0062);
    @(posedge clock);
    #1;
    checks++;
    if (pulse_cnt - p0 !== 1 || pass_cnt - ok0 !== 1) begin
      errors++;
      $display("FAIL single_ok: got %0d pulses/%0d ok, want 1/1", pulse_cnt - p0, pass_cnt - ok0);
    end
    p0 = pulse_cnt; ok0 = pass_cnt;
    send_frame(q, 32'h0062_0063);
    @(posedge clock);
    #1;
    checks++;
    if (pulse_cnt - p0 !== 1 || pass_cnt - ok0 !== 0) begin
      errors++;
      $display("FAIL single_bad: got %0d pulses/%0d ok, want 1/0", pulse_cnt - p0, pass_cnt - ok0);
    end
  endtask

  task automatic test_modulus;
    logic [7:0] q[$];
    int p0, ok0;
    q = {};
    for (int i = 0; i < 257; i++) q.push_back(8'hFF);
    p0 = pulse_cnt; ok0 = pass_cnt;
    send_frame(q, 32'h080F_000F);
    @(posedge clock);
    #1;
    checks++;
    if (pulse_cnt - p0 !== 1 || pass_cnt - ok0 !== 1) begin
      errors++;
      $display("FAIL modulus_ok: got %0d pulses/%0d ok, want 1/1", pulse_cnt - p0, pass_cnt - ok0);
    end
    checks++;
    if (pulse_comp !== 32'h080F_000F) begin
      errors++; $display("FAIL modulus_computed: got %h, want 080f000f", pulse_comp);
    end
  endtask

  task automatic test_gaps;
    logic [7:0] q[$];
    logic [31:0] ck;
    int p0, ok0, w;
    wiki(q);
    ck = 32'h11E6_0398;
    p0 = pulse_cnt; ok0 = pass_cnt;
    for (int i = 0; i < 13; i++) begin
      // Idle cycles carry junk data and a stray last_data that must be ignored.
      for (int g = 0; g < (i % 3); g++) begin
        bus.data_valid = 1'b0;
        bus.last_data  = 1'b1;
        bus.data       = 8'hAA;
        @(posedge clock);
        #1;
      end
      if (i < 9) send(q[i], (i == 8), w);
      else send(ck[8*(12-i) +: 8], 1'b1, w);
    end
    checks++;
    if (bus.computed !== 32'h11E6_0398) begin
      errors++; $display("FAIL gaps_report_computed: got %h, want 11e60398", bus.computed);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (pulse_cnt - p0 !== 1 || pass_cnt - ok0 !== 1) begin
      errors++;
      $display("FAIL gaps_verdict: got %0d pulses/%0d ok, want 1/1", pulse_cnt - p0, pass_cnt - ok0);
    end
  endtask

  task automatic test_back_to_back;
    int p0, ok0, r0, w;
    p0 = pulse_cnt; ok0 = pass_cnt; r0 = ready_low_cnt;
    send(8'h61, 1'b1, w);
    send(8'h00, 1'b0, w); send(8'h62, 1'b0, w); send(8'h00, 1'b0, w); send(8'h62, 1'b0, w);
    // Now in the REPORT cycle: the next frame's first byte is presented and held.
    send(8'h61, 1'b1, w);
    checks++;
    if (w !== 1) begin
      errors++; $display("FAIL b2b_accept_delay: got %0d wait cycles, want 1", w);
    end
    send(8'h00, 1'b0, w); send(8'h62, 1'b0, w); send(8'h00, 1'b0, w); send(8'h62, 1'b0, w);
    @(posedge clock);
    #1;
    checks++;
    if (pulse_cnt - p0 !== 2 || pass_cnt - ok0 !== 2) begin
      errors++;
      $display("FAIL b2b_verdicts: got %0d pulses/%0d ok, want 2/2", pulse_cnt - p0, pass_cnt - ok0);
    end
    checks++;
    if (ready_low_cnt - r0 !== 2) begin
      errors++; $display("FAIL b2b_ready_low: got %0d cycles, want 2", ready_low_cnt - r0);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] q[$];
    int p0, ok0, w;
    p0 = pulse_cnt; ok0 = pass_cnt;
    send(8'h61, 1'b1, w);
    send(8'h00, 1'b0, w);
    send(8'h62, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.computed !== 32'h0000_0001 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: got computed=%h ready=%b, want 00000001/1",
               bus.computed, bus.ready);
    end
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    q = '{8'h61};
    send_frame(q, 32'h0062_0062);
    @(posedge clock);
    #1;
    checks++;
    if (pulse_cnt - p0 !== 1 || pass_cnt - ok0 !== 1) begin
      errors++;
      $display("FAIL midreset_verdict: got %0d pulses/%0d ok, want 1/1",
               pulse_cnt - p0, pass_cnt - ok0);
    end
  endtask

  initial begin
    test_reset();
    test_wikipedia();
    test_single_byte();
    test_modulus();
    test_gaps();
    test_back_to_back();
    test_reset_midframe();
    checks++;
    if (stray_ok_cnt !== 0) begin
      errors++; $display("FAIL stray_checksum_ok: got %0d cycles, want 0", stray_ok_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adler32_checker.md
Name: adler32_checker

Overview:
Receive-side counterpart of the Adler-32 generator. It consumes a framed byte stream: payload bytes, with the last one flagged, followed by the 4-byte Adler-32 checksum sent most-significant byte first. It recomputes the checksum over the payload, captures the trailing 4 bytes, and reports pass/fail with a one-cycle result pulse. It sits at a link or storage read port, downstream of the byte source.

Parameters:
MODULUS, 65521, Adler-32 modulus. Applied with a single conditional subtract; must be > 255 and < 2^16.

Ports:
clock  input  1  system clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
data_valid  input  1  qualifies data; a byte is accepted only when data_valid=1 and ready=1
last_data  input  1  marks the accepted byte as the final payload byte; meaningful only with data_valid in PAYLOAD
data  input  8  stream byte
ready  output  1  block can accept a byte this cycle
result_valid  output  1  one-cycle pulse, frame verdict available
checksum_ok  output  1  1 = received checksum equals computed; valid only with result_valid, else 0
computed  output  32  live {B[15:0], A[15:0]} running checksum

Behaviour:
- Reset (async, rst_n=0):
  - state=PAYLOAD; A=1; B=0; byte counter=0; received register=0.
  - result_valid=0; checksum_ok=0; ready=1; computed=0x00000001.
- Arithmetic on each accepted PAYLOAD byte:
  - sumA = A + data (17 bit); A' = sumA >= MODULUS ? sumA - MODULUS : sumA.
  - sumB = B + A' (17 bit); B' = same conditional subtract.
  - Registers update on the clock edge of acceptance. One subtract suffices because A, B < MODULUS.
- FSM, 3 states:
  - PAYLOAD: ready=1. An accepted byte updates A/B.
    - If last_data=1 on that byte, go to CKSUM and clear the counter.
    - last_data without data_valid is ignored.
    - The payload is therefore at least 1 byte.
  - CKSUM: ready=1. Accepted bytes shift into the received register MSB-first: received = {received[23:0], data}. A/B are frozen; the counter increments.
    - On the 4th accepted byte (counter==3), go to REPORT.
    - last_data is ignored in this state.
  - REPORT: lasts exactly 1 cycle.
    - ready=0; result_valid=1; checksum_ok = (received == {B,A}); computed still shows the frame checksum.
    - Any data_valid in this cycle is not accepted.
    - At the end of the cycle: A=1, B=0, counter=0, go to PAYLOAD.
- Latency: result_valid asserts in the cycle immediately after the clock edge that accepts the 4th checksum byte.
- Gaps: cycles with data_valid=0 change no state in any FSM state. Arbitrary idle gaps are allowed anywhere.
- Back-to-back frames: the first byte of the next frame is accepted in the cycle after REPORT.
- Reset mid-frame (any state): the partial frame is discarded without a result pulse. The next frame is verified correctly from scratch.
- ready is a pure function of state (0 only in REPORT). It never depends combinationally on data_valid.

Test Plan:
- ASCII "Wikipedia" (9 bytes, last_data on 'a'), then 0x11,0xE6,0x03,0x98 -> one result_valid pulse with checksum_ok=1; computed=0x11E60398 during REPORT.
- Single payload byte 0x61 with last_data, then 0x00,0x62,0x00,0x62 -> checksum_ok=1. Repeat with last byte 0x63 -> result_valid=1, checksum_ok=0.
- 257 bytes of 0xFF, then 0x08,0x0F,0x00,0x0F -> checksum_ok=1 (A wraps to 0x000F, B=0x080F). Exercises the modulus subtract on both A and B.
- "Wikipedia" frame with random data_valid=0 gaps in payload and checksum, plus last_data pulsed high on idle cycles and during CKSUM -> identical verdict (ok=1), exactly one result pulse.
- Two frames back-to-back with the next frame's first byte presented during REPORT and held -> byte accepted the cycle after REPORT; both verdicts correct; ready=0 for exactly one cycle per frame.
- rst_n low asynchronously after 2 checksum bytes, then a fresh 0x61 frame -> no result pulse for the aborted frame; computed=0x00000001 immediately after reset; second frame checksum_ok=1.
